// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: word-addressed instruction memory behind a
// req/gnt/rvalid fetch bus, with a fixed response latency, an outstanding
// request limit, optional periodic grant stalls and a preload write port.
module instr_mem_responder #(
   parameter int          MEM_WORDS       = 1024,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int          LATENCY         = 1,
   parameter int          MAX_OUTSTANDING = 2,
   parameter int          STALL_PERIOD    = 0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   input  logic [31:0] instr_addr_i,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        load_we_i,
   input  logic [31:0] load_addr_i,
   input  logic [31:0] load_wdata_i
);

   localparam int               IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int               OUT_W       = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [31:0]      MEM_WORDS_C = 32'(MEM_WORDS);
   localparam logic [OUT_W-1:0] MAX_OUT_C   = OUT_W'(MAX_OUTSTANDING);
   localparam logic [OUT_W-1:0] ONE_OUT_C   = OUT_W'(1);

   // Out-of-range test: below the base, or word index past the array end.
   // The below-base test comes first so the wrapped 32-bit offset of a
   // low address never masquerades as a valid index.
   function automatic logic addr_err_f(input logic [31:0] addr);
      logic [31:0] offset_v;
      logic [31:0] word_v;
      offset_v = addr - BASE_ADDR;
      word_v   = {2'b00, offset_v[31:2]};
      return (addr < BASE_ADDR) || (word_v >= MEM_WORDS_C);
   endfunction

   // Word index of a byte address; the byte offset bits are ignored.
   function automatic logic [IDX_W-1:0] addr_idx_f(input logic [31:0] addr);
      logic [31:0] offset_v;
      offset_v = addr - BASE_ADDR;
      return offset_v[IDX_W+1:2];
   endfunction

   logic [31:0]      mem_r [MEM_WORDS];

   logic             fetch_err_s;
   logic [IDX_W-1:0] fetch_idx_s;
   logic             load_err_s;
   logic [IDX_W-1:0] load_idx_s;
   logic             stall_slot_s;
   logic             gnt_s;
   logic             accept_s;
   logic [31:0]      acc_data_s;

   logic             tail_vld_s;
   logic [31:0]      tail_data_s;
   logic             tail_err_s;

   logic [OUT_W-1:0] outstanding_r;
   logic             rvalid_r;
   logic [31:0]      rdata_r;
   logic             err_r;

   // Address decode, grant and array read for the request seen this cycle.
   always_comb begin
      fetch_err_s = addr_err_f(instr_addr_i);
      fetch_idx_s = addr_idx_f(instr_addr_i);
      load_err_s  = addr_err_f(load_addr_i);
      load_idx_s  = addr_idx_f(load_addr_i);
      gnt_s       = 1'b0;
      if (instr_req_i && (outstanding_r < MAX_OUT_C) && !stall_slot_s) begin
         gnt_s = 1'b1;
      end else begin
         gnt_s = 1'b0;
      end
      accept_s   = instr_req_i & gnt_s;
      acc_data_s = 32'h0000_0000;
      if (fetch_err_s) begin
         acc_data_s = 32'h0000_0000;
      end else begin
         // Read happens before this edge's preload lands, so a same-cycle
         // write to the same word returns the old contents.
         acc_data_s = mem_r[fetch_idx_s];
      end
   end

   // Preload port: one word per cycle, out-of-range writes dropped.
   always_ff @(posedge clk) begin
      if (load_we_i && !load_err_s) begin
         mem_r[load_idx_s] <= load_wdata_i;
      end
   end

   generate
      if (STALL_PERIOD > 0) begin : g_stall
         localparam int               CNT_W  = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
         localparam logic [CNT_W-1:0] LAST_C = CNT_W'(STALL_PERIOD - 1);
         localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
         logic [CNT_W-1:0] stall_cnt_r;

         // Free-running modulo counter; its last count is the stall slot.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               stall_cnt_r <= '0;
            end else if (stall_cnt_r == LAST_C) begin
               stall_cnt_r <= '0;
            end else begin
               stall_cnt_r <= stall_cnt_r + ONE_C;
            end
         end

         assign stall_slot_s = (stall_cnt_r == LAST_C);
      end else begin : g_no_stall
         assign stall_slot_s = 1'b0;
      end
   endgenerate

   generate
      if (LATENCY == 1) begin : g_direct
         assign tail_vld_s  = accept_s;
         assign tail_data_s = acc_data_s;
         assign tail_err_s  = fetch_err_s;
      end else begin : g_pipe
         localparam int DEPTH = LATENCY - 1;
         logic        pipe_vld_r  [DEPTH];
         logic [31:0] pipe_data_r [DEPTH];
         logic        pipe_err_r  [DEPTH];

         // Latency shift pipe feeding the output stage; cleared on reset so
         // in-flight responses are dropped rather than replayed.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               for (int i = 0; i < DEPTH; i++) begin
                  pipe_vld_r[i]  <= 1'b0;
                  pipe_data_r[i] <= 32'h0000_0000;
                  pipe_err_r[i]  <= 1'b0;
               end
            end else begin
               pipe_vld_r[0]  <= accept_s;
               pipe_data_r[0] <= acc_data_s;
               pipe_err_r[0]  <= fetch_err_s;
               for (int i = 1; i < DEPTH; i++) begin
                  pipe_vld_r[i]  <= pipe_vld_r[i-1];
                  pipe_data_r[i] <= pipe_data_r[i-1];
                  pipe_err_r[i]  <= pipe_err_r[i-1];
               end
            end
         end

         assign tail_vld_s  = pipe_vld_r[DEPTH-1];
         assign tail_data_s = pipe_data_r[DEPTH-1];
         assign tail_err_s  = pipe_err_r[DEPTH-1];
      end
   endgenerate

   // Output stage: rdata holds between responses, err only qualifies rvalid.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rvalid_r <= 1'b0;
         rdata_r  <= 32'h0000_0000;
         err_r    <= 1'b0;
      end else if (tail_vld_s) begin
         rvalid_r <= 1'b1;
         rdata_r  <= tail_data_s;
         err_r    <= tail_err_s;
      end else begin
         rvalid_r <= 1'b0;
         err_r    <= 1'b0;
      end
   end

   // Outstanding count. A request retires on the edge that raises rvalid,
   // so a slot frees in the same cycle its response appears; this gives
   // MAX_OUTSTANDING/LATENCY throughput and full rate at LATENCY=1.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         outstanding_r <= '0;
      end else begin
         case ({accept_s, tail_vld_s})
            2'b10: begin
               if (outstanding_r < MAX_OUT_C) begin
                  outstanding_r <= outstanding_r + ONE_OUT_C;
               end else begin
                  outstanding_r <= outstanding_r;
               end
            end
            2'b01: begin
               if (outstanding_r != '0) begin
                  outstanding_r <= outstanding_r - ONE_OUT_C;
               end else begin
                  outstanding_r <= outstanding_r;
               end
            end
            default: outstanding_r <= outstanding_r;
         endcase
      end
   end

   assign instr_gnt_o    = gnt_s;
   assign instr_rvalid_o = rvalid_r;
   assign instr_rdata_o  = rdata_r;
   assign instr_err_o    = err_r;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder using three configurations:
//  a: LATENCY=1, base 0      b: LATENCY=3, MAX=2, base 0x100, 16 words
//  c: LATENCY=2, MAX=2, STALL_PERIOD=4
module tb_instr_mem_responder;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   total = 0;
   int   bad = 0;

   logic        a_req = 1'b0, a_we = 1'b0;
   logic [31:0] a_addr = 32'h0, a_laddr = 32'h0, a_wdata = 32'h0;
   logic        a_gnt, a_rvalid, a_err;
   logic [31:0] a_rdata;

   logic        b_req = 1'b0, b_we = 1'b0;
   logic [31:0] b_addr = 32'h0, b_laddr = 32'h0, b_wdata = 32'h0;
   logic        b_gnt, b_rvalid, b_err;
   logic [31:0] b_rdata;

   logic        c_req = 1'b0, c_we = 1'b0;
   logic [31:0] c_addr = 32'h0, c_laddr = 32'h0, c_wdata = 32'h0;
   logic        c_gnt, c_rvalid, c_err;
   logic [31:0] c_rdata;

   always #5 clk = ~clk;

   instr_mem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1),
                         .MAX_OUTSTANDING(2), .STALL_PERIOD(0)) dut_a (
      .clk(clk), .rstn(rstn),
      .instr_req_i(a_req), .instr_gnt_o(a_gnt), .instr_addr_i(a_addr),
      .instr_rvalid_o(a_rvalid), .instr_rdata_o(a_rdata), .instr_err_o(a_err),
      .load_we_i(a_we), .load_addr_i(a_laddr), .load_wdata_i(a_wdata));

   instr_mem_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h100), .LATENCY(3),
                         .MAX_OUTSTANDING(2), .STALL_PERIOD(0)) dut_b (
      .clk(clk), .rstn(rstn),
      .instr_req_i(b_req), .instr_gnt_o(b_gnt), .instr_addr_i(b_addr),
      .instr_rvalid_o(b_rvalid), .instr_rdata_o(b_rdata), .instr_err_o(b_err),
      .load_we_i(b_we), .load_addr_i(b_laddr), .load_wdata_i(b_wdata));

   instr_mem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0), .LATENCY(2),
                         .MAX_OUTSTANDING(2), .STALL_PERIOD(4)) dut_c (
      .clk(clk), .rstn(rstn),
      .instr_req_i(c_req), .instr_gnt_o(c_gnt), .instr_addr_i(c_addr),
      .instr_rvalid_o(c_rvalid), .instr_rdata_o(c_rdata), .instr_err_o(c_err),
      .load_we_i(c_we), .load_addr_i(c_laddr), .load_wdata_i(c_wdata));

   // Each bench cycle: drive just after the falling edge, sample 1 time unit later.
   task automatic test_reset();
      repeat (3) @(negedge clk);
      #1;
      total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", a_rvalid); end
      total++; if (a_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", a_err); end
      total++; if (a_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", a_rdata); end
      total++; if (b_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt_noreq got=%b exp=0", b_gnt); end
      @(negedge clk); rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_fetch();
      @(negedge clk); a_we = 1'b1; a_laddr = 32'h0; a_wdata = 32'h0000_0013;
      @(negedge clk); a_laddr = 32'h4; a_wdata = 32'h0010_0093;
      @(negedge clk); a_we = 1'b0; a_req = 1'b1; a_addr = 32'h0; #1;
      total++; if (a_gnt !== 1'b1) begin bad++; $display("FAIL basic_gnt0 got=%b exp=1", a_gnt); end
      @(negedge clk); a_addr = 32'h4; #1;
      total++; if (a_gnt !== 1'b1) begin bad++; $display("FAIL basic_gnt1 got=%b exp=1", a_gnt); end
      total++; if ({a_rvalid, a_err, a_rdata} !== {1'b1, 1'b0, 32'h0000_0013})
         begin bad++; $display("FAIL basic_rsp0 got=%b/%b/%h exp=1/0/00000013", a_rvalid, a_err, a_rdata); end
      @(negedge clk); a_req = 1'b0; #1;
      total++; if ({a_rvalid, a_err, a_rdata} !== {1'b1, 1'b0, 32'h0010_0093})
         begin bad++; $display("FAIL basic_rsp1 got=%b/%b/%h exp=1/0/00100093", a_rvalid, a_err, a_rdata); end
      @(negedge clk); #1;
      total++; if ({a_rvalid, a_err, a_rdata} !== {1'b0, 1'b0, 32'h0010_0093})
         begin bad++; $display("FAIL basic_hold got=%b/%b/%h exp=0/0/00100093", a_rvalid, a_err, a_rdata); end
   endtask

   task automatic test_collision();
      @(negedge clk); a_we = 1'b1; a_laddr = 32'h14; a_wdata = 32'hAAAA_AAAA;
      @(negedge clk); a_wdata = 32'h5555_5555; a_req = 1'b1; a_addr = 32'h14; #1;
      total++; if (a_gnt !== 1'b1) begin bad++; $display("FAIL coll_gnt got=%b exp=1", a_gnt); end
      @(negedge clk); a_we = 1'b0; #1;
      total++; if ({a_rvalid, a_rdata} !== {1'b1, 32'hAAAA_AAAA})
         begin bad++; $display("FAIL coll_old got=%b/%h exp=1/aaaaaaaa", a_rvalid, a_rdata); end
      @(negedge clk); a_req = 1'b0; #1;
      total++; if ({a_rvalid, a_rdata} !== {1'b1, 32'h5555_5555})
         begin bad++; $display("FAIL coll_new got=%b/%h exp=1/55555555", a_rvalid, a_rdata); end
      @(negedge clk);
   endtask

   task automatic test_range();
      @(negedge clk); b_we = 1'b1; b_laddr = 32'h100; b_wdata = 32'hCAFE_0000;
      @(negedge clk); b_laddr = 32'h104; b_wdata = 32'h1234_5678;
      @(negedge clk); b_laddr = 32'h13C; b_wdata = 32'hBEEF_0015;
      @(negedge clk); b_laddr = 32'h140; b_wdata = 32'hDEAD_DEAD;  // beyond the array
      @(negedge clk); b_we = 1'b0; b_req = 1'b1; b_addr = 32'h13C; #1;
      total++; if (b_gnt !== 1'b1) begin bad++; $display("FAIL range_gnt_last got=%b exp=1", b_gnt); end
      @(negedge clk); b_addr = 32'h100; #1;
      total++; if (b_gnt !== 1'b1) begin bad++; $display("FAIL range_gnt_first got=%b exp=1", b_gnt); end
      @(negedge clk); b_req = 1'b0; #1;
      total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL range_early got=%b exp=0", b_rvalid); end
      @(negedge clk); #1;
      total++; if ({b_rvalid, b_err, b_rdata} !== {1'b1, 1'b0, 32'hBEEF_0015})
         begin bad++; $display("FAIL range_last_word got=%b/%b/%h exp=1/0/beef0015", b_rvalid, b_err, b_rdata); end
      @(negedge clk); #1;
      total++; if ({b_rvalid, b_err, b_rdata} !== {1'b1, 1'b0, 32'hCAFE_0000})
         begin bad++; $display("FAIL range_drop_write got=%b/%b/%h exp=1/0/cafe0000", b_rvalid, b_err, b_rdata); end
      @(negedge clk);
      @(negedge clk); b_req = 1'b1; b_addr = 32'h140; #1;
      total++; if (b_gnt !== 1'b1) begin bad++; $display("FAIL range_gnt_hi got=%b exp=1", b_gnt); end
      @(negedge clk); b_addr = 32'h2; #1;
      total++; if (b_gnt !== 1'b1) begin bad++; $display("FAIL range_gnt_lo got=%b exp=1", b_gnt); end
      @(negedge clk); b_req = 1'b0;
      @(negedge clk); #1;
      total++; if ({b_rvalid, b_err, b_rdata} !== {1'b1, 1'b1, 32'h0})
         begin bad++; $display("FAIL range_err_hi got=%b/%b/%h exp=1/1/00000000", b_rvalid, b_err, b_rdata); end
      @(negedge clk); #1;
      total++; if ({b_rvalid, b_err, b_rdata} !== {1'b1, 1'b1, 32'h0})
         begin bad++; $display("FAIL range_err_lo got=%b/%b/%h exp=1/1/00000000", b_rvalid, b_err, b_rdata); end
      @(negedge clk); #1;
      total++; if ({b_rvalid, b_err} !== 2'b00)
         begin bad++; $display("FAIL range_err_drop got=%b/%b exp=0/0", b_rvalid, b_err); end
   endtask

   task automatic test_outstanding_limit();
      logic exp_g;
      logic exp_v;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         b_req = (i < 9) ? 1'b1 : 1'b0;
         b_addr = 32'h104;
         #1;
         if (i < 9) begin
            exp_g = ((i % 3) != 2) ? 1'b1 : 1'b0;
            total++; if (b_gnt !== exp_g) begin bad++; $display("FAIL limit_gnt[%0d] got=%b exp=%b", i, b_gnt, exp_g); end
         end
         exp_v = (i == 3 || i == 4 || i == 6 || i == 7 || i == 9 || i == 10) ? 1'b1 : 1'b0;
         total++; if (b_rvalid !== exp_v) begin bad++; $display("FAIL limit_rvalid[%0d] got=%b exp=%b", i, b_rvalid, exp_v); end
         if (exp_v) begin
            total++; if (b_rdata !== 32'h1234_5678) begin bad++; $display("FAIL limit_rdata[%0d] got=%h exp=12345678", i, b_rdata); end
         end
      end
   endtask

   task automatic test_reset_in_flight();
      @(negedge clk); b_req = 1'b1; b_addr = 32'h100; #1;
      total++; if (b_gnt !== 1'b1) begin bad++; $display("FAIL rif_gnt0 got=%b exp=1", b_gnt); end
      @(negedge clk); b_addr = 32'h104; #1;
      total++; if (b_gnt !== 1'b1) begin bad++; $display("FAIL rif_gnt1 got=%b exp=1", b_gnt); end
      @(negedge clk); b_req = 1'b0; rstn = 1'b0; #1;
      total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL rif_in_reset got=%b exp=0", b_rvalid); end
      @(negedge clk); rstn = 1'b1; #1;
      total++; if (b_rdata !== 32'h0) begin bad++; $display("FAIL rif_rdata_clr got=%h exp=0", b_rdata); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL rif_stale[%0d] got=%b exp=0", i, b_rvalid); end
      end
      @(negedge clk); b_req = 1'b1; b_addr = 32'h104; #1;
      total++; if (b_gnt !== 1'b1) begin bad++; $display("FAIL rif_gnt_after got=%b exp=1", b_gnt); end
      @(negedge clk); b_req = 1'b0;
      @(negedge clk); #1;
      total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL rif_early got=%b exp=0", b_rvalid); end
      @(negedge clk); #1;
      total++; if ({b_rvalid, b_err, b_rdata} !== {1'b1, 1'b0, 32'h1234_5678})
         begin bad++; $display("FAIL rif_rsp got=%b/%b/%h exp=1/0/12345678", b_rvalid, b_err, b_rdata); end
      // Array contents survive reset.
      @(negedge clk); a_req = 1'b1; a_addr = 32'h4;
      @(negedge clk); a_req = 1'b0; #1;
      total++; if ({a_rvalid, a_rdata} !== {1'b1, 32'h0010_0093})
         begin bad++; $display("FAIL rif_mem_kept got=%b/%h exp=1/00100093", a_rvalid, a_rdata); end
   endtask

   task automatic test_stall();
      logic g [16];
      logic v [16];
      logic exp_g [16];
      logic exp_v;
      int   k;
      k = -1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         c_req = (i < 12) ? 1'b1 : 1'b0;
         c_addr = 32'h8;
         #1;
         g[i] = c_gnt;
         v[i] = c_rvalid;
      end
      for (int i = 3; i >= 0; i--) begin
         if (g[i] === 1'b0) k = i;
      end
      total++;
      if (k < 0) begin
         bad++; $display("FAIL stall_phase got=none exp=one low gnt in first 4 cycles");
      end else begin
         for (int i = 0; i < 16; i++) begin
            exp_g[i] = (i < 12) && (((i + 4 - k) % 4) != 0);
         end
         for (int i = 0; i < 12; i++) begin
            total++; if (g[i] !== exp_g[i]) begin bad++; $display("FAIL stall_gnt[%0d] got=%b exp=%b", i, g[i], exp_g[i]); end
         end
         for (int i = 0; i < 16; i++) begin
            exp_v = (i >= 2) ? exp_g[i-2] : 1'b0;
            total++; if (v[i] !== exp_v) begin bad++; $display("FAIL stall_rvalid[%0d] got=%b exp=%b", i, v[i], exp_v); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_collision();
      test_range();
      test_outstanding_limit();
      test_reset_in_flight();
      test_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule
